// File: rtl/stp_coeff_writer_pkg.sv
// Shared constants and state encodings for the STP coefficient writer
// and the EVP evaluator that reads the same S/N RAMs.
package stp_coeff_writer_pkg;

  localparam int MAX_DEG     = 10;
  localparam int SLOT_STRIDE = MAX_DEG + 1;

  localparam logic [31:0] STATUS_OK   = 32'h0000_0000;
  localparam logic [31:0] STATUS_ERR  = 32'h0000_0002;
  localparam logic [31:0] STATUS_IDLE = 32'hFFFF_FFFF;

  localparam logic [4:0] N_ERR_MARK = 5'b11111;

  typedef enum logic [2:0] {
    STP_IDLE,
    STP_CHECK,
    STP_WR_N,
    STP_WR_COEFF,
    STP_OUTPUT,
    STP_ERROR,
    STP_END
  } stp_state_t;

  typedef enum logic [2:0] {
    EVP_IDLE,
    EVP_RD_N,
    EVP_CHECK,
    EVP_MAC,
    EVP_OUTPUT,
    EVP_ERROR,
    EVP_END
  } evp_state_t;

endpackage

// File: rtl/stp_coeff_writer_addr_gen.sv
// Coefficient index counter and S RAM address generator.
// Address is slot*11 + idx, built from shifts and adds.
module stp_addr_gen
  import stp_coeff_writer_pkg::*;
#(
  parameter int AW   = 3,
  parameter int S_AW = 7
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  input  logic [AW-1:0]   slot,
  input  logic [4:0]      deg,
  output logic [S_AW-1:0] addr,
  output logic            last
);

  logic [3:0]      idx;
  logic [S_AW-1:0] a_ext;
  logic [S_AW-1:0] i_ext;

  // Index of the next coefficient to accept within the slot.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= idx + 4'd1;
    end
  end

  assign a_ext = S_AW'(slot);
  assign i_ext = S_AW'(idx);
  assign addr  = (a_ext << 3) + (a_ext << 1) + a_ext + i_ext;
  assign last  = ({1'b0, idx} == deg);

endmodule

// File: rtl/stp_coeff_writer.sv
// STP command engine: writes degree to the N RAM and drains the
// coefficient FIFO into the S RAM slot, or marks a bad degree.
module stp_coeff_writer
  import stp_coeff_writer_pkg::*;
#(
  parameter int SLOTS   = 8,
  parameter int MAX_DEG = 10,
  parameter int S_AW    = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_stp,
  input  logic [$clog2(SLOTS)-1:0] A,
  input  logic [4:0]               N,
  input  logic [15:0]              coeff_data,
  input  logic                     coeff_valid,
  output logic                     coeff_pop,
  output logic                     en_wr_S,
  output logic [S_AW-1:0]          wr_addr_S,
  output logic [15:0]              wr_data_S,
  output logic                     en_wr_N,
  output logic [$clog2(SLOTS)-1:0] wr_addr_N,
  output logic [4:0]               wr_data_N,
  output logic                     done_stp,
  output logic [31:0]              status
);

  localparam int AW = $clog2(SLOTS);

  stp_state_t      state;
  logic [AW-1:0]   a_reg;
  logic [4:0]      n_reg;
  logic [S_AW-1:0] s_addr;
  logic            last;
  logic            idx_clr;

  assign coeff_pop = (state == STP_WR_COEFF) & coeff_valid;
  assign idx_clr   = (state == STP_CHECK);

  stp_addr_gen #(
    .AW   (AW),
    .S_AW (S_AW)
  ) u_addr_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (idx_clr),
    .inc  (coeff_pop),
    .slot (a_reg),
    .deg  (n_reg),
    .addr (s_addr),
    .last (last)
  );

  // Command FSM with registered RAM write ports and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= STP_IDLE;
      a_reg     <= '0;
      n_reg     <= '0;
      en_wr_S   <= 1'b0;
      wr_addr_S <= '0;
      wr_data_S <= '0;
      en_wr_N   <= 1'b0;
      wr_addr_N <= '0;
      wr_data_N <= '0;
      done_stp  <= 1'b0;
      status    <= STATUS_IDLE;
    end else begin
      en_wr_S  <= 1'b0;
      en_wr_N  <= 1'b0;
      done_stp <= 1'b0;
      unique case (state)
        STP_IDLE: begin
          if (start_stp) begin
            a_reg  <= A;
            n_reg  <= N;
            status <= STATUS_IDLE;
            state  <= STP_CHECK;
          end
        end
        STP_CHECK: begin
          if (n_reg > 5'(MAX_DEG)) begin
            state <= STP_ERROR;
          end else begin
            state <= STP_WR_N;
          end
        end
        STP_WR_N: begin
          en_wr_N   <= 1'b1;
          wr_addr_N <= a_reg;
          wr_data_N <= n_reg;
          state     <= STP_WR_COEFF;
        end
        STP_WR_COEFF: begin
          if (coeff_valid) begin
            en_wr_S   <= 1'b1;
            wr_addr_S <= s_addr;
            wr_data_S <= coeff_data;
            if (last) begin
              state <= STP_OUTPUT;
            end
          end
        end
        STP_OUTPUT: begin
          status   <= STATUS_OK;
          done_stp <= 1'b1;
          state    <= STP_END;
        end
        STP_ERROR: begin
          en_wr_N   <= 1'b1;
          wr_addr_N <= a_reg;
          wr_data_N <= N_ERR_MARK;
          status    <= STATUS_ERR;
          done_stp  <= 1'b1;
          state     <= STP_END;
        end
        STP_END: begin
          state <= STP_IDLE;
        end
        default: begin
          state <= STP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stp_coeff_writer.sv
// Scoreboard bench for stp_coeff_writer: expected RAM writes and
// completions are queued at issue time and checked by a monitor.
module tb_stp_coeff_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_stp = 1'b0;
  logic [2:0]  A = '0;
  logic [4:0]  N = '0;
  logic [15:0] coeff_data;
  logic        coeff_valid;
  logic        coeff_pop;
  logic        en_wr_S;
  logic [6:0]  wr_addr_S;
  logic [15:0] wr_data_S;
  logic        en_wr_N;
  logic [2:0]  wr_addr_N;
  logic [4:0]  wr_data_N;
  logic        done_stp;
  logic [31:0] status;

  int asserts = 0;
  int fails   = 0;
  int cyc     = 0;
  int pops    = 0;

  logic [15:0] fifo[$];
  int          fifo_n = 0;
  logic [15:0] head = '0;
  logic        gate = 1'b1;
  logic        toggle = 1'b0;
  logic        phase = 1'b0;

  logic [22:0] exp_s[$];
  logic [7:0]  exp_n[$];
  logic [31:0] exp_st[$];
  int          exp_dc[$];

  assign coeff_valid = gate && (fifo_n > 0) && (!toggle || phase);
  assign coeff_data  = head;

  stp_coeff_writer dut (
    .clk         (clk),
    .rst         (rst),
    .start_stp   (start_stp),
    .A           (A),
    .N           (N),
    .coeff_data  (coeff_data),
    .coeff_valid (coeff_valid),
    .coeff_pop   (coeff_pop),
    .en_wr_S     (en_wr_S),
    .wr_addr_S   (wr_addr_S),
    .wr_data_S   (wr_data_S),
    .en_wr_N     (en_wr_N),
    .wr_addr_N   (wr_addr_N),
    .wr_data_N   (wr_data_N),
    .done_stp    (done_stp),
    .status      (status)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void refresh();
    fifo_n = fifo.size();
    head   = (fifo_n > 0) ? fifo[0] : 16'h0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // FIFO model: pop the head when the DUT accepted it at this edge.
  initial begin
    logic p;
    forever begin
      @(posedge clk);
      p = coeff_pop && !rst;
      #1;
      if (p) begin
        void'(fifo.pop_front());
        pops++;
      end
      phase = ~phase;
      refresh();
    end
  end

  // Monitor: compare every RAM write and completion against queues.
  always @(negedge clk) begin
    logic [22:0] es;
    logic [7:0]  en;
    logic [31:0] est;
    int          edc;
    if (!rst) begin
      chk("wr exclusive", {31'd0, en_wr_S & en_wr_N}, 32'd0);
      if (en_wr_S) begin
        if (exp_s.size() == 0) begin
          chk("unexpected S write", {25'd0, wr_addr_S}, 32'hDEAD);
        end else begin
          es = exp_s.pop_front();
          chk("S addr", {25'd0, wr_addr_S}, {25'd0, es[22:16]});
          chk("S data", {16'd0, wr_data_S}, {16'd0, es[15:0]});
        end
      end
      if (en_wr_N) begin
        if (exp_n.size() == 0) begin
          chk("unexpected N write", {29'd0, wr_addr_N}, 32'hDEAD);
        end else begin
          en = exp_n.pop_front();
          chk("N addr", {29'd0, wr_addr_N}, {29'd0, en[7:5]});
          chk("N data", {27'd0, wr_data_N}, {27'd0, en[4:0]});
        end
      end
      if (done_stp) begin
        if (exp_st.size() == 0) begin
          chk("unexpected done", status, 32'hDEAD);
        end else begin
          est = exp_st.pop_front();
          edc = exp_dc.pop_front();
          chk("done status", status, est);
          if (edc >= 0) chk("done latency", cyc, edc);
        end
      end
    end
  end

  // Queue a command's expected effects, load its tokens, pulse start.
  task automatic run(input logic [2:0] a, input logic [4:0] n,
                     input logic [15:0] base, input bit lat);
    logic [15:0] d;
    if (n <= 5'd10) begin
      for (int i = 0; i <= int'(n); i++) begin
        d = base + 16'(2 * i);
        fifo.push_back(d);
        exp_s.push_back({7'(int'(a) * 11 + i), d});
      end
      refresh();
      exp_n.push_back({a, n});
      exp_st.push_back(32'h0);
      exp_dc.push_back(lat ? cyc + 5 + int'(n) : -1);
    end else begin
      exp_n.push_back({a, 5'b11111});
      exp_st.push_back(32'h2);
      exp_dc.push_back(lat ? cyc + 3 : -1);
    end
    A = a;
    N = n;
    start_stp = 1'b1;
    tick();
    start_stp = 1'b0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_s.size() + exp_n.size() + exp_st.size()) != 0
           && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) chk({name, " timeout"}, 32'd1, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int k;
    refresh();
    rst = 1'b1;
    tick();
    tick();
    chk("rst en_wr_S", {31'd0, en_wr_S}, 32'd0);
    chk("rst en_wr_N", {31'd0, en_wr_N}, 32'd0);
    chk("rst wr_addr_S", {25'd0, wr_addr_S}, 32'd0);
    chk("rst done", {31'd0, done_stp}, 32'd0);
    chk("rst status", status, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();

    // A=3, N=2, coefficients 5,7,9
    p0 = pops;
    run(3'd3, 5'd2, 16'd5, 1'b1);
    chk("busy status", status, 32'hFFFF_FFFF);
    drain("t1");
    chk("t1 pops", pops - p0, 32'd3);
    chk("t1 status", status, 32'h0);

    // Degree error with tokens waiting
    fifo.push_back(16'h1111);
    fifo.push_back(16'h2222);
    refresh();
    p0 = pops;
    run(3'd0, 5'd11, 16'h0, 1'b1);
    drain("t2");
    chk("t2 no pops", pops - p0, 32'd0);
    chk("t2 status", status, 32'h2);
    fifo.delete();
    refresh();

    // Degree 31 is also an error
    run(3'd5, 5'd31, 16'h0, 1'b1);
    drain("t2b");

    // A=7, N=10 with FIFO valid toggling
    toggle = 1'b1;
    p0 = pops;
    run(3'd7, 5'd10, 16'hA000, 1'b0);
    drain("t3");
    toggle = 1'b0;
    chk("t3 pops", pops - p0, 32'd11);
    chk("t3 status", status, 32'h0);

    // A=1, N=0, single coefficient 16'hFFFF
    p0 = pops;
    run(3'd1, 5'd0, 16'hFFFF, 1'b1);
    drain("t4");
    chk("t4 pops", pops - p0, 32'd1);

    // Reset after two of five coefficients
    p0 = pops;
    for (int i = 0; i < 3; i++) fifo.push_back(16'h2000 + 16'(2 * i));
    refresh();
    exp_n.push_back({3'd2, 5'd4});
    exp_s.push_back({7'd22, 16'h2000});
    exp_s.push_back({7'd23, 16'h2002});
    A = 3'd2;
    N = 5'd4;
    start_stp = 1'b1;
    tick();
    start_stp = 1'b0;
    k = 0;
    while (pops - p0 < 2 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("t5 pop timeout", 32'd1, 32'd0);
    gate = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("t5 en_wr_S", {31'd0, en_wr_S}, 32'd0);
    chk("t5 wr_addr_S", {25'd0, wr_addr_S}, 32'd0);
    chk("t5 wr_data_S", {16'd0, wr_data_S}, 32'd0);
    chk("t5 en_wr_N", {31'd0, en_wr_N}, 32'd0);
    chk("t5 wr_data_N", {27'd0, wr_data_N}, 32'd0);
    chk("t5 done", {31'd0, done_stp}, 32'd0);
    chk("t5 status", status, 32'hFFFF_FFFF);
    rst = 1'b0;
    gate = 1'b1;
    repeat (4) tick();
    chk("t5 pop after rst", {31'd0, coeff_pop}, 32'd0);
    chk("t5 pops", pops - p0, 32'd2);
    chk("t5 queues", exp_s.size() + exp_n.size(), 32'd0);
    fifo.delete();
    refresh();
    run(3'd2, 5'd0, 16'h3000, 1'b1);
    drain("t5b");

    // Second start during WR_COEFF is ignored
    p0 = pops;
    run(3'd4, 5'd3, 16'h4000, 1'b1);
    tick();
    tick();
    A = 3'd6;
    N = 5'd1;
    start_stp = 1'b1;
    tick();
    start_stp = 1'b0;
    drain("t6");
    repeat (10) tick();
    chk("t6 pops", pops - p0, 32'd4);
    chk("t6 status", status, 32'h0);

    chk("end S queue", exp_s.size(), 32'd0);
    chk("end done queue", exp_st.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

endmodule
